// File: rtl/pwm_servo_driver.sv
// Signed controller output to PWM duty + direction for an H-bridge, with a
// once-per-period sample strobe and dead time inserted on direction reversal.
module pwm_servo_driver #(
    parameter int Magnitud = 17,
    parameter int Decimal  = 0,
    parameter int N        = Magnitud + Decimal + 1,
    parameter int PERIOD   = 1000,
    parameter int CW       = 10,
    parameter int DEADTIME = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [N-1:0]  u,
    output logic          pwm_out,
    output logic          dir,
    output logic          sample_tick,
    output logic [CW-1:0] duty,
    output logic          sat,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [CW-1:0] L_PERIOD_CW = CW'(PERIOD);
    localparam logic [CW-1:0] L_LAST      = CW'(PERIOD - 1);
    localparam logic [CW-1:0] L_DEAD      = CW'(DEADTIME);
    localparam logic [CW-1:0] L_DEAD_LAST = CW'(DEADTIME - 1);
    localparam logic [N:0]    L_PERIOD_N  = (N + 1)'(PERIOD);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] r_duty;
    logic          r_dir;
    logic          r_sat;

    logic          w_wrap;
    logic          w_capture;
    logic [N:0]    w_u_ext;
    logic [N:0]    w_abs;
    logic [N:0]    w_mag;
    logic          w_over;
    logic [CW-1:0] w_duty_new;
    logic          w_dir_new;
    logic          w_reverse;
    logic          w_pwm;

    assign w_wrap    = (r_cnt == L_LAST);
    assign w_capture = enable && (r_state != IDLE) && w_wrap;

    // One extra bit so that |most-negative u| stays a positive magnitude.
    assign w_u_ext    = {u[N-1], u};
    assign w_abs      = u[N-1] ? (~w_u_ext + 1'b1) : w_u_ext;
    assign w_mag      = w_abs >> Decimal;
    assign w_over     = (w_mag > L_PERIOD_N);
    assign w_duty_new = w_over ? L_PERIOD_CW : w_mag[CW-1:0];
    assign w_dir_new  = (u == '0) ? r_dir : u[N-1];
    assign w_reverse  = (w_dir_new != r_dir) && (w_duty_new != '0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (enable) w_state_next = RUN;
            end
            RUN, DEAD: begin
                if (!enable) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_wrap)
                        w_state_next = w_reverse ? DEAD : RUN;
                    else if ((r_state == DEAD) && (r_cnt == L_DEAD_LAST))
                        w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_dir   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Shadow load only at period end so duty never changes mid-period.
            if (w_capture) begin
                r_duty <= w_duty_new;
                r_dir  <= w_dir_new;
                r_sat  <= w_over;
            end
        end
    end

    always_comb begin
        w_pwm = 1'b0;
        case (r_state)
            RUN:     w_pwm = (r_cnt < r_duty);
            DEAD:    w_pwm = (r_cnt >= L_DEAD) && (r_cnt < r_duty);
            default: w_pwm = 1'b0;
        endcase
    end

    assign pwm_out     = w_pwm;
    assign sample_tick = w_capture;
    assign duty        = r_duty;
    assign dir         = r_dir;
    assign sat         = r_sat;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_servo_driver.sv
// Scoreboard bench for pwm_servo_driver: per-period records (pwm mask, duty,
// dir, sat) are queued by the driver and popped by a monitor on each sample_tick.
module tb_pwm_servo_driver;

    localparam int PERIOD   = 10;
    localparam int DEADTIME = 2;
    localparam int CW       = 4;
    localparam int N        = 18;
    localparam int N2       = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          enable2;
    logic [N-1:0]  u;
    logic [N2-1:0] u2;

    logic          pwm_out, dir, sample_tick, sat;
    logic [CW-1:0] duty;
    logic [1:0]    dbg_state;
    logic          pwm2, dir2, tick2, sat2;
    logic [CW-1:0] duty2;
    logic [1:0]    dbg2;

    // {pwm mask (bit i = cnt i), duty, dir, sat}
    logic [15:0] exp_q[$];
    // {duty, dir, sat}
    logic [5:0]  exp2_q[$];

    int n_pass  = 0;
    int n_total = 0;

    logic        m_active;
    int          m_pos;
    logic [9:0]  m_mask;

    pwm_servo_driver #(
        .Magnitud(17), .Decimal(0), .PERIOD(PERIOD), .CW(CW), .DEADTIME(DEADTIME)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .u(u),
        .pwm_out(pwm_out), .dir(dir), .sample_tick(sample_tick),
        .duty(duty), .sat(sat), .o_dbg_state(dbg_state)
    );

    pwm_servo_driver #(
        .Magnitud(17), .Decimal(4), .PERIOD(PERIOD), .CW(CW), .DEADTIME(DEADTIME)
    ) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .u(u2),
        .pwm_out(pwm2), .dir(dir2), .sample_tick(tick2),
        .duty(duty2), .sat(sat2), .o_dbg_state(dbg2)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] rec(input logic [9:0] m, input logic [3:0] d,
                                        input logic dr, input logic s);
        return {m, d, dr, s};
    endfunction

    function automatic logic [5:0] rec2(input logic [3:0] d, input logic dr, input logic s);
        return {d, dr, s};
    endfunction

    // ---------------- period position model ----------------
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_pos    <= 0;
        end else if (!enable) begin
            m_active <= 1'b0;
            m_pos    <= 0;
        end else if (!m_active) begin
            m_active <= 1'b1;
            m_pos    <= 0;
        end else begin
            m_pos <= (m_pos == PERIOD - 1) ? 0 : m_pos + 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic        exp_tick;
        logic [15:0] e;
        exp_tick = m_active && enable && (m_pos == PERIOD - 1);
        check("tick", sample_tick, exp_tick);
        check("state_idle", dbg_state == 2'd0, !m_active);
        if (!m_active) begin
            check("idle_pwm", pwm_out, 1'b0);
        end else begin
            if (m_pos == 0) m_mask = '0;
            m_mask[m_pos] = pwm_out;
        end
        if (exp_tick) begin
            check("sb_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pwm_mask", m_mask, e[15:6]);
                check("duty", duty, e[5:2]);
                check("dir", dir, e[1]);
                check("sat", sat, e[0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e2;
        if (tick2) begin
            check("sb2_avail", exp2_q.size() != 0, 1'b1);
            if (exp2_q.size() != 0) begin
                e2 = exp2_q.pop_front();
                check("duty2", duty2, e2[5:2]);
                check("dir2", dir2, e2[1]);
                check("sat2", sat2, e2[0]);
            end
        end
        if (dbg2 == 2'd0) check("idle_pwm2", pwm2, 1'b0);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tick();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                got = 1'b1;
                break;
            end
        end
        check("tick_timeout", got, 1'b1);
    endtask

    // Returns 1 time unit into cnt==0 of the next period.
    task automatic next_period();
        wait_tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        enable2 = 1'b1;
        u       = 18'd5;
        u2      = 22'd100;
        repeat (3) @(negedge clk);
        check("rst_duty", duty, 4'd0);
        check("rst_dir", dir, 1'b0);
        check("rst_sat", sat, 1'b0);
        check("rst_tick", sample_tick, 1'b0);

        exp_q.push_back(rec(10'h000, 4'd0, 1'b0, 1'b0));
        exp_q.push_back(rec(10'h01F, 4'd5, 1'b0, 1'b0));
        exp2_q.push_back(rec2(4'd0, 1'b0, 1'b0));
        exp2_q.push_back(rec2(4'd6, 1'b0, 1'b0));
        reset = 1'b1;

        next_period();  // period 2
        u  = 18'd25;
        u2 = -22'sd100;
        exp_q.push_back(rec(10'h3FF, 4'd10, 1'b0, 1'b1));
        exp2_q.push_back(rec2(4'd6, 1'b1, 1'b0));

        next_period();  // period 3
        u  = 18'h20000;
        u2 = 22'd0;
        exp_q.push_back(rec(10'h3FC, 4'd10, 1'b1, 1'b1));
        exp2_q.push_back(rec2(4'd0, 1'b1, 1'b0));

        next_period();  // period 4
        u = 18'd6;
        exp_q.push_back(rec(10'h03C, 4'd6, 1'b0, 1'b0));

        next_period();  // period 5
        enable2 = 1'b0;
        exp_q.push_back(rec(10'h03F, 4'd6, 1'b0, 1'b0));

        next_period();  // period 6
        u = -18'sd3;
        exp_q.push_back(rec(10'h004, 4'd3, 1'b1, 1'b0));

        next_period();  // period 7
        exp_q.push_back(rec(10'h007, 4'd3, 1'b1, 1'b0));

        next_period();  // period 8: u wiggles mid-period, only the final value counts
        u = 18'd9;
        repeat (3) begin @(posedge clk); #1; end
        check("hold_duty", duty, 4'd3);
        u = -18'sd8;

        next_period();  // period 9, abandoned at cnt 4
        repeat (4) begin @(posedge clk); #1; end
        enable = 1'b0;
        @(posedge clk); #1;
        u = 18'd1;
        repeat (4) begin @(posedge clk); #1; end
        check("idle_duty", duty, 4'd8);
        check("idle_dir", dir, 1'b1);
        u = -18'sd8;
        exp_q.push_back(rec(10'h0FF, 4'd8, 1'b1, 1'b0));
        exp_q.push_back(rec(10'h0FF, 4'd8, 1'b1, 1'b0));
        enable = 1'b1;

        next_period();  // period 10
        u = 18'd0;
        exp_q.push_back(rec(10'h000, 4'd0, 1'b1, 1'b0));

        next_period();  // period 11
        u = 18'd2;
        exp_q.push_back(rec(10'h000, 4'd2, 1'b0, 1'b0));

        next_period();  // period 12
        next_period();  // period 13, reset mid-pulse
        @(posedge clk); #3;
        check("pre_arst_pwm", pwm_out, 1'b1);
        reset = 1'b0;
        #1;
        check("arst_pwm", pwm_out, 1'b0);
        check("arst_tick", sample_tick, 1'b0);
        check("arst_duty", duty, 4'd0);

        @(negedge clk);
        exp_q.push_back(rec(10'h000, 4'd0, 1'b0, 1'b0));
        exp_q.push_back(rec(10'h003, 4'd2, 1'b0, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        wait_tick();
        wait_tick();
        @(posedge clk); #1;
        check("sb_drained", exp_q.size(), 0);
        check("sb2_drained", exp2_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
